// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared peripheral bus.
// One transaction in flight at a time: grant in IDLE, drive bus in ISSUE, report in RESP.

`ifndef MEM_BUS_DEFS
`define MEM_BUS_DEFS
`define ADDR_W        32
`define WORD_W        32
`define MEM_COUNT_W   2
`define MEM_CODE_W    2
`define MEM_CODE_WAIT 2'd0
`endif

module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_m0_req_valid,
    input  logic [`ADDR_W-1:0]       i_m0_req_addr,
    input  logic [`WORD_W-1:0]       i_m0_req_wr_data,
    input  logic                     i_m0_req_wr_en,
    input  logic [`MEM_COUNT_W-1:0]  i_m0_req_count,
    output logic                     o_m0_req_ready,
    output logic                     o_m0_res_valid,
    output logic [`WORD_W-1:0]       o_m0_res_rd_data,
    output logic [`MEM_CODE_W-1:0]   o_m0_res_code,
    output logic                     o_m0_res_timeout,
    input  logic                     i_m1_req_valid,
    input  logic [`ADDR_W-1:0]       i_m1_req_addr,
    input  logic [`WORD_W-1:0]       i_m1_req_wr_data,
    input  logic                     i_m1_req_wr_en,
    input  logic [`MEM_COUNT_W-1:0]  i_m1_req_count,
    output logic                     o_m1_req_ready,
    output logic                     o_m1_res_valid,
    output logic [`WORD_W-1:0]       o_m1_res_rd_data,
    output logic [`MEM_CODE_W-1:0]   o_m1_res_code,
    output logic                     o_m1_res_timeout,
    output logic [`ADDR_W-1:0]       o_bus_req_addr,
    output logic [`WORD_W-1:0]       o_bus_req_wr_data,
    output logic                     o_bus_req_wr_en,
    output logic [`MEM_COUNT_W-1:0]  o_bus_req_count,
    input  logic [`WORD_W-1:0]       i_bus_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]   i_bus_res_code
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    lastGrant_q, lastGrant_d;
    logic [`ADDR_W-1:0]      addr_q, addr_d;
    logic [`WORD_W-1:0]      wrData_q, wrData_d;
    logic                    wrEn_q, wrEn_d;
    logic [`MEM_COUNT_W-1:0] count_q, count_d;
    logic [7:0]              cycleCnt_q, cycleCnt_d;
    logic [`WORD_W-1:0]      rdData_q, rdData_d;
    logic [`MEM_CODE_W-1:0]  code_q, code_d;
    logic                    timeout_q, timeout_d;
    logic                    pick;

    // lastGrant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            addr_q      <= '0;
            wrData_q    <= '0;
            wrEn_q      <= 1'b0;
            count_q     <= '0;
            cycleCnt_q  <= '0;
            rdData_q    <= '0;
            code_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            wrData_q    <= wrData_d;
            wrEn_q      <= wrEn_d;
            count_q     <= count_d;
            cycleCnt_q  <= cycleCnt_d;
            rdData_q    <= rdData_d;
            code_q      <= code_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        lastGrant_d    = lastGrant_q;
        addr_d         = addr_q;
        wrData_d       = wrData_q;
        wrEn_d         = wrEn_q;
        count_d        = count_q;
        cycleCnt_d     = cycleCnt_q;
        rdData_d       = rdData_q;
        code_d         = code_q;
        timeout_d      = timeout_q;
        o_m0_req_ready = 1'b0;
        o_m1_req_ready = 1'b0;
        pick           = (i_m0_req_valid && i_m1_req_valid) ? ~lastGrant_q : i_m1_req_valid;

        case (state_q)
            IDLE: begin
                if (i_m0_req_valid || i_m1_req_valid) begin
                    o_m0_req_ready = ~pick;
                    o_m1_req_ready = pick;
                    grant_d        = pick;
                    lastGrant_d    = pick;
                    addr_d         = pick ? i_m1_req_addr    : i_m0_req_addr;
                    wrData_d       = pick ? i_m1_req_wr_data : i_m0_req_wr_data;
                    wrEn_d         = pick ? i_m1_req_wr_en   : i_m0_req_wr_en;
                    count_d        = pick ? i_m1_req_count   : i_m0_req_count;
                    cycleCnt_d     = '0;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                // A terminal code wins over the timeout limit in the same cycle.
                if (i_bus_res_code != `MEM_CODE_WAIT) begin
                    rdData_d  = i_bus_res_rd_data;
                    code_d    = i_bus_res_code;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (cycleCnt_q == CNT_LIMIT) begin
                    rdData_d  = '0;
                    code_d    = `MEM_CODE_WAIT;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cycleCnt_d = cycleCnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_bus_req_addr    = (state_q == ISSUE) ? addr_q   : '0;
    assign o_bus_req_wr_data = (state_q == ISSUE) ? wrData_q : '0;
    assign o_bus_req_wr_en   = (state_q == ISSUE) && wrEn_q;
    assign o_bus_req_count   = (state_q == ISSUE) ? count_q  : '0;

    assign o_m0_res_valid   = (state_q == RESP) && !grant_q;
    assign o_m0_res_rd_data = o_m0_res_valid ? rdData_q : '0;
    assign o_m0_res_code    = o_m0_res_valid ? code_q   : '0;
    assign o_m0_res_timeout = o_m0_res_valid && timeout_q;

    assign o_m1_res_valid   = (state_q == RESP) && grant_q;
    assign o_m1_res_rd_data = o_m1_res_valid ? rdData_q : '0;
    assign o_m1_res_code    = o_m1_res_valid ? code_q   : '0;
    assign o_m1_res_timeout = o_m1_res_valid && timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: read, write, wait states, timeout boundary,
// round-robin contention and reset during an in-flight transaction.

`ifndef MEM_BUS_DEFS
`define MEM_BUS_DEFS
`define ADDR_W        32
`define WORD_W        32
`define MEM_COUNT_W   2
`define MEM_CODE_W    2
`define MEM_CODE_WAIT 2'd0
`endif

module tb_mem_bus_arbiter;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    m0Valid, m1Valid;
    logic [`ADDR_W-1:0]      m0Addr, m1Addr;
    logic [`WORD_W-1:0]      m0WrData, m1WrData;
    logic                    m0WrEn, m1WrEn;
    logic [`MEM_COUNT_W-1:0] m0Count, m1Count;
    logic                    m0Ready, m1Ready;
    logic                    m0ResValid, m1ResValid;
    logic [`WORD_W-1:0]      m0ResData, m1ResData;
    logic [`MEM_CODE_W-1:0]  m0ResCode, m1ResCode;
    logic                    m0ResTimeout, m1ResTimeout;
    logic [`ADDR_W-1:0]      busAddr;
    logic [`WORD_W-1:0]      busWrData;
    logic                    busWrEn;
    logic [`MEM_COUNT_W-1:0] busCount;
    logic [`WORD_W-1:0]      busRdData;
    logic [`MEM_CODE_W-1:0]  busCode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .i_m0_req_valid(m0Valid), .i_m0_req_addr(m0Addr), .i_m0_req_wr_data(m0WrData),
        .i_m0_req_wr_en(m0WrEn), .i_m0_req_count(m0Count), .o_m0_req_ready(m0Ready),
        .o_m0_res_valid(m0ResValid), .o_m0_res_rd_data(m0ResData),
        .o_m0_res_code(m0ResCode), .o_m0_res_timeout(m0ResTimeout),
        .i_m1_req_valid(m1Valid), .i_m1_req_addr(m1Addr), .i_m1_req_wr_data(m1WrData),
        .i_m1_req_wr_en(m1WrEn), .i_m1_req_count(m1Count), .o_m1_req_ready(m1Ready),
        .o_m1_res_valid(m1ResValid), .o_m1_res_rd_data(m1ResData),
        .o_m1_res_code(m1ResCode), .o_m1_res_timeout(m1ResTimeout),
        .o_bus_req_addr(busAddr), .o_bus_req_wr_data(busWrData),
        .o_bus_req_wr_en(busWrEn), .o_bus_req_count(busCount),
        .i_bus_res_rd_data(busRdData), .i_bus_res_code(busCode)
    );

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0Valid = 1'b0; m0Addr = '0; m0WrData = '0; m0WrEn = 1'b0; m0Count = '0;
        m1Valid = 1'b0; m1Addr = '0; m1WrData = '0; m1WrEn = 1'b0; m1Count = '0;
        busRdData = '0; busCode = `MEM_CODE_WAIT;

        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("rst_m0_ready", 64'(m0Ready), 64'd0);
        checkOutput("rst_m0_res_valid", 64'(m0ResValid), 64'd0);
        checkOutput("rst_m1_res_valid", 64'(m1ResValid), 64'd0);
        checkOutput("rst_bus_addr", 64'(busAddr), 64'd0);
        checkOutput("rst_bus_wr_en", 64'(busWrEn), 64'd0);

        // Single read from m0, answered in the first ISSUE cycle.
        applyStimulus();
        reset = 1'b0;
        m0Valid = 1'b1; m0Addr = 32'h10; m0WrEn = 1'b0; m0Count = 2'd2;
        settle();
        checkOutput("rd_m0_ready_T", 64'(m0Ready), 64'd1);
        checkOutput("rd_m1_ready_T", 64'(m1Ready), 64'd0);
        checkOutput("rd_bus_addr_idle", 64'(busAddr), 64'd0);
        applyStimulus();
        m0Valid = 1'b0;
        busCode = 2'd1; busRdData = 32'hA5;
        settle();
        checkOutput("rd_bus_addr_T1", 64'(busAddr), 64'h10);
        checkOutput("rd_bus_wr_en_T1", 64'(busWrEn), 64'd0);
        checkOutput("rd_m0_ready_T1", 64'(m0Ready), 64'd0);
        applyStimulus();
        busCode = `MEM_CODE_WAIT; busRdData = '0;
        settle();
        checkOutput("rd_m0_res_valid_T2", 64'(m0ResValid), 64'd1);
        checkOutput("rd_m0_res_data_T2", 64'(m0ResData), 64'hA5);
        checkOutput("rd_m0_res_code_T2", 64'(m0ResCode), 64'd1);
        checkOutput("rd_m0_res_timeout_T2", 64'(m0ResTimeout), 64'd0);
        checkOutput("rd_m1_res_valid_T2", 64'(m1ResValid), 64'd0);
        checkOutput("rd_bus_addr_T2", 64'(busAddr), 64'd0);
        applyStimulus();
        settle();
        checkOutput("rd_m0_res_valid_T3", 64'(m0ResValid), 64'd0);

        // Write from m1; bus wr_en must be high only during ISSUE.
        m1Valid = 1'b1; m1Addr = 32'h20; m1WrData = 32'hDEADBEEF; m1WrEn = 1'b1; m1Count = 2'd2;
        settle();
        checkOutput("wr_m1_ready", 64'(m1Ready), 64'd1);
        checkOutput("wr_m0_ready", 64'(m0Ready), 64'd0);
        checkOutput("wr_bus_wr_en_idle", 64'(busWrEn), 64'd0);
        applyStimulus();
        m1Valid = 1'b0;
        busCode = 2'd1;
        settle();
        checkOutput("wr_bus_wr_en_issue", 64'(busWrEn), 64'd1);
        checkOutput("wr_bus_wr_data_issue", 64'(busWrData), 64'hDEADBEEF);
        checkOutput("wr_bus_count_issue", 64'(busCount), 64'd2);
        applyStimulus();
        busCode = `MEM_CODE_WAIT;
        settle();
        checkOutput("wr_bus_wr_en_resp", 64'(busWrEn), 64'd0);
        checkOutput("wr_bus_wr_data_resp", 64'(busWrData), 64'd0);
        checkOutput("wr_m1_res_valid", 64'(m1ResValid), 64'd1);
        checkOutput("wr_m0_res_valid", 64'(m0ResValid), 64'd0);

        // Three wait states, then terminal code 2 on the fourth ISSUE cycle.
        applyStimulus();
        m0Valid = 1'b1; m0Addr = 32'h30; m0WrEn = 1'b0;
        settle();
        checkOutput("ws_m0_ready", 64'(m0Ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            m0Valid = 1'b0;
            if (i == 3) begin
                busCode = 2'd2; busRdData = 32'h77;
            end
            settle();
            checkOutput($sformatf("ws_bus_addr_%0d", i), 64'(busAddr), 64'h30);
            checkOutput($sformatf("ws_res_valid_%0d", i), 64'(m0ResValid), 64'd0);
        end
        applyStimulus();
        busCode = `MEM_CODE_WAIT; busRdData = '0;
        settle();
        checkOutput("ws_m0_res_valid", 64'(m0ResValid), 64'd1);
        checkOutput("ws_m0_res_data", 64'(m0ResData), 64'h77);
        checkOutput("ws_m0_res_code", 64'(m0ResCode), 64'd2);
        checkOutput("ws_m0_res_timeout", 64'(m0ResTimeout), 64'd0);

        // Timeout: m1 read stuck at WAIT for exactly 16 ISSUE cycles.
        applyStimulus();
        m1Valid = 1'b1; m1Addr = 32'h40; m1WrEn = 1'b0;
        settle();
        checkOutput("to_m1_ready", 64'(m1Ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            m1Valid = 1'b0;
            busRdData = 32'hFFFF;
            settle();
            checkOutput($sformatf("to_bus_addr_%0d", i), 64'(busAddr), 64'h40);
            checkOutput($sformatf("to_res_valid_%0d", i), 64'(m1ResValid), 64'd0);
        end
        applyStimulus();
        busRdData = '0;
        settle();
        checkOutput("to_m1_res_valid", 64'(m1ResValid), 64'd1);
        checkOutput("to_m1_res_timeout", 64'(m1ResTimeout), 64'd1);
        checkOutput("to_m1_res_data", 64'(m1ResData), 64'd0);
        checkOutput("to_m1_res_code", 64'(m1ResCode), 64'(`MEM_CODE_WAIT));
        checkOutput("to_bus_addr_resp", 64'(busAddr), 64'd0);

        // Terminal code arriving on the timeout-limit cycle beats the timeout.
        applyStimulus();
        m0Valid = 1'b1; m0Addr = 32'h50;
        settle();
        checkOutput("tb_m0_ready", 64'(m0Ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            m0Valid = 1'b0;
            if (i == 15) begin
                busCode = 2'd3; busRdData = 32'h55;
            end
            settle();
        end
        checkOutput("tb_bus_addr_last", 64'(busAddr), 64'h50);
        applyStimulus();
        busCode = `MEM_CODE_WAIT; busRdData = '0;
        settle();
        checkOutput("tb_m0_res_valid", 64'(m0ResValid), 64'd1);
        checkOutput("tb_m0_res_timeout", 64'(m0ResTimeout), 64'd0);
        checkOutput("tb_m0_res_code", 64'(m0ResCode), 64'd3);
        checkOutput("tb_m0_res_data", 64'(m0ResData), 64'h55);

        // Contention: both always valid, last grant was m0 so m1 goes first here.
        applyStimulus();
        m0Valid = 1'b1; m0Addr = 32'h100; m0WrEn = 1'b0;
        m1Valid = 1'b1; m1Addr = 32'h200; m1WrEn = 1'b0;
        busCode = 2'd1; busRdData = 32'h99;
        for (int i = 0; i < 4; i++) begin
            logic expM1;
            expM1 = (i % 2 == 0);
            settle();
            checkOutput($sformatf("rr_m0_ready_%0d", i), 64'(m0Ready), 64'(!expM1));
            checkOutput($sformatf("rr_m1_ready_%0d", i), 64'(m1Ready), 64'(expM1));
            applyStimulus();
            settle();
            checkOutput($sformatf("rr_bus_addr_%0d", i), 64'(busAddr), expM1 ? 64'h200 : 64'h100);
            checkOutput($sformatf("rr_ready_held_%0d", i), 64'(m0Ready | m1Ready), 64'd0);
            applyStimulus();
            settle();
            checkOutput($sformatf("rr_m0_res_valid_%0d", i), 64'(m0ResValid), 64'(!expM1));
            checkOutput($sformatf("rr_m1_res_valid_%0d", i), 64'(m1ResValid), 64'(expM1));
            applyStimulus();
        end

        // Reset during the second ISSUE cycle of an m1 write drops it silently.
        m0Valid = 1'b0;
        m1Valid = 1'b1; m1Addr = 32'h60; m1WrData = 32'h12345678; m1WrEn = 1'b1;
        busCode = `MEM_CODE_WAIT;
        settle();
        checkOutput("mr_m1_ready", 64'(m1Ready), 64'd1);
        applyStimulus();
        m1Valid = 1'b0;
        applyStimulus();
        reset = 1'b1;
        settle();
        checkOutput("mr_bus_wr_en_issue2", 64'(busWrEn), 64'd1);
        applyStimulus();
        reset = 1'b0;
        m0Valid = 1'b1; m0Addr = 32'h70; m0WrEn = 1'b0;
        m1Valid = 1'b1; m1Addr = 32'h80;
        settle();
        checkOutput("mr_bus_addr_after", 64'(busAddr), 64'd0);
        checkOutput("mr_bus_wr_en_after", 64'(busWrEn), 64'd0);
        checkOutput("mr_m1_res_valid", 64'(m1ResValid), 64'd0);
        checkOutput("mr_tie_m0_ready", 64'(m0Ready), 64'd1);
        checkOutput("mr_tie_m1_ready", 64'(m1Ready), 64'd0);
        applyStimulus();
        m0Valid = 1'b0; m1Valid = 1'b0;
        busCode = 2'd1;
        settle();
        checkOutput("mr_bus_addr_m0", 64'(busAddr), 64'h70);
        checkOutput("mr_m1_res_valid_2", 64'(m1ResValid), 64'd0);
        applyStimulus();
        busCode = `MEM_CODE_WAIT;
        settle();
        checkOutput("mr_m0_res_valid", 64'(m0ResValid), 64'd1);
        checkOutput("mr_m1_res_valid_3", 64'(m1ResValid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: number of ISSUE cycles without a terminal response before the transaction is abandonedof; legal range 2..255.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: reset that is synchronous and active-high.
REQ-004 Ports i_m0_req_valid / i_m1_req_valid, input, 1 each: requester N has a pending request.
REQ-005 Ports i_mN_req_addr `ADDR_W, i_mN_req_wr_data `WORD_W, i_mN_req_wr_en 1, i_mN_req_count `MEM_COUNT_W, input: request fields, N in {0,1}.
REQ-006 Ports o_mN_req_ready, output, 1: request accepted this cycle.
REQ-007 Ports o_mN_res_valid 1, o_mN_res_rd_data `WORD_W, o_mN_res_code `MEM_CODE_W, o_mN_res_timeout 1, output: response to requester N.
REQ-008 Ports o_bus_req_addr `ADDR_W, o_bus_req_wr_data `WORD_W, o_bus_req_wr_en 1, o_bus_req_count `MEM_COUNT_W, output: shared peripheral bus request.
REQ-009 Ports i_bus_res_rd_data `WORD_W, i_bus_res_code `MEM_CODE_W, input: shared bus response, combinational from peripherals.

Function
REQ-010 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-011 IDLE: o_mN_req_ready SHALL be combinational, asserted for exactly one granted requester whose valid is high; the other SHALL see ready low.
REQ-012 Arbitration: one valid requester is granted; if both are valid, the requester not granted last is granted (round-robin); last-grant SHALL update only on grant.
REQ-013 On grant, addr/wr_data/wr_en/count and grant index SHALL be registered; next state ISSUE.
REQ-014 ISSUE: the bus outputs SHALL present the registered request; in IDLE and RESP the bus outputs SHALL be all zero (wr_en low).
REQ-015 ISSUE: o_mN_req_ready SHALL be low for both requesters; in RESP as well.
REQ-016 ISSUE: if i_bus_res_code != `MEM_CODE_WAIT, rd_data and code SHALL be captured, timeout flag cleared; next state RESP.
REQ-017 ISSUE: an 8-bit cycle counter, cleared on entry, SHALL increment each ISSUE cycle; when it equals TIMEOUT_CYCLES-1 with code still `MEM_CODE_WAIT`, capture rd_data=0, code=`MEM_CODE_WAIT`, timeout flag=1; next state RESP.
REQ-018 A terminal code in the same cycle as the timeout limit SHALL take priority (no timeout).
REQ-019 RESP: o_mN_res_valid SHALL be high for exactly one cycle, for the granted requester only, with captured rd_data, code, timeout; next state IDLE.
REQ-020 Response outputs of the non-granted requester, and of both outside RESP, SHALL be zero.
REQ-021 Minimum latency: grant at cycle T, first bus cycle T+1, res_valid at T+2 for a peripheral answering in its first cycle.
REQ-022 Requests arriving in ISSUE/RESP SHALL be held off (ready low) and considered in the next IDLE cycle; no request SHALL be lost or duplicated.

Reset
REQ-023 While reset is high at a clock edge: state IDLE, counter 0, last-grant = requester 1 (requester 0 wins first tie), captured registers 0.
REQ-024 All registered outputs SHALL be zero after reset; an in-flight transaction SHALL be dropped with no res_valid.

Verification
REQ-025 Single read: m0 valid addr 0x10, wr_en 0; bus code terminal 1st ISSUE cycle, rd_data 0xA5 -> m0 ready at T, bus addr 0x10 at T+1, m0 res_valid at T+2 with data 0xA5, timeout 0.
REQ-026 Contention: m0, m1 both valid continuously from reset -> grants alternate m0, m1, m0, m1; each res_valid routed only to its granted requester.
REQ-027 Wait states: code `MEM_CODE_WAIT` for 3 ISSUE cycles then terminal -> bus request held stable 4 cycles, res_valid 1 cycle later, timeout 0.
REQ-028 Timeout: code stuck at `MEM_CODE_WAIT`, TIMEOUT_CYCLES=16 -> exactly 16 ISSUE cycles, then res_valid with timeout 1, rd_data 0.
REQ-029 Reset mid-ISSUE: assert reset during 2nd ISSUE cycle of an m1 write -> next cycle IDLE, bus outputs 0, no m1 res_valid; next tie grants m0.
REQ-030 Write: m1 wr_en 1, data 0xDEADBEEF, count word -> bus wr_en high only in ISSUE cycles, zero in IDLE/RESP.
